// File: rtl/dpram_pkg.sv
// Shared constants and types for the parametrised dual-port RAM.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then
// parks in READY and raises init_done until the next reset.
module dpram_clear_ctrl
  import dpram_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              init_done_q, init_done_d;

  // State, pointer and done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic and clear-write strobe.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    clr_addr    = ptr_q;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  assign init_done = init_done_q;

endmodule

// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM with post-reset clear,
// selectable same-port read-during-write, port-A-priority write collision
// arbitration and a saturating collision counter.
// Optional macro DPRAM_OUT_REG_EN adds a second output register per port.
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int RDW_MODE = 0,
  parameter  int CNT_W    = 8,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              init_done,
  output logic              collision,
  output logic [CNT_W-1:0]  coll_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              in_a, in_b, pw_a, pw_b;
  logic              mem_we_a, mem_we_b;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_din_a;

  logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic              collision_q, collision_d;
  logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;

  dpram_clear_ctrl #(
    .DEPTH (DEPTH)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_done (init_done)
  );

  // Port decode, write arbitration, first-stage read data and collision count.
  always_comb begin
    in_a        = ({1'b0, addr_a} < DEPTH_L);
    in_b        = ({1'b0, addr_b} < DEPTH_L);
    pw_a        = init_done & en_a & we_a & in_a;
    pw_b        = init_done & en_b & we_b & in_b;
    collision_d = pw_a & pw_b & (addr_a == addr_b);

    // Clear writes share the port A write path; the two never overlap
    // because port writes require init_done.
    mem_we_a    = clr_we | pw_a;
    mem_addr_a  = clr_we ? clr_addr : addr_a;
    mem_din_a   = clr_we ? '0 : din_a;
    mem_we_b    = pw_b & ~collision_d;

    rd_a_d = rd_a_q;
    if (init_done && en_a) begin
      if (!in_a)                                   rd_a_d = '0;
      else if (we_a && RDW_MODE == RDW_WRITE_FIRST) rd_a_d = din_a;
      else                                         rd_a_d = mem_q[addr_a];
    end

    rd_b_d = rd_b_q;
    if (init_done && en_b) begin
      if (!in_b)                                   rd_b_d = '0;
      else if (we_b && RDW_MODE == RDW_WRITE_FIRST) rd_b_d = din_b;
      else                                         rd_b_d = mem_q[addr_b];
    end

    coll_cnt_d = coll_cnt_q;
    if (collision_d && coll_cnt_q != '1) coll_cnt_d = coll_cnt_q + 1'b1;
  end

  // Storage array; not reset, contents are cleared by the sequencer.
  always_ff @(posedge clk) begin
    if (mem_we_b) mem_q[addr_b]     <= din_b;
    if (mem_we_a) mem_q[mem_addr_a] <= mem_din_a;
  end

  // First-stage read registers and collision status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      collision_q <= collision_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic              ren_a_q, ren_a_d, ren_b_q, ren_b_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;

  // Second stage loads whenever the first stage was enabled a cycle earlier.
  always_comb begin
    ren_a_d = init_done & en_a;
    ren_b_d = init_done & en_b;
    out_a_d = ren_a_q ? rd_a_q : out_a_q;
    out_b_d = ren_b_q ? rd_b_q : out_b_q;
  end

  // Output pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_a_q <= 1'b0;
      ren_b_q <= 1'b0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      ren_a_q <= ren_a_d;
      ren_b_q <= ren_b_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign dout_a = out_a_q;
  assign dout_b = out_b_q;
`else
  assign dout_a = rd_a_q;
  assign dout_b = rd_b_q;
`endif

  assign collision = collision_q;
  assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Randomised bench for dual_port_ram_param: two instances (16 words
// read-first, 12 words write-first) share one stimulus stream and are
// checked against an array-based reference model.
module tb_dual_port_ram_param;

  localparam int NI = 2;

  logic       clk, rst_n;
  logic       en_a, we_a, en_b, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;

  logic [7:0] dout_a_o [NI];
  logic [7:0] dout_b_o [NI];
  logic       init_done_o [NI];
  logic       collision_o [NI];
  logic [7:0] coll_cnt_o [NI];

  int errors = 0;
  int checks = 0;

  dual_port_ram_param #(.DATA_W(8), .DEPTH(16), .RDW_MODE(0), .CNT_W(8)) u_ram16 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a_o[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b_o[0]),
    .init_done(init_done_o[0]), .collision(collision_o[0]), .coll_cnt(coll_cnt_o[0])
  );

  dual_port_ram_param #(.DATA_W(8), .DEPTH(12), .RDW_MODE(1), .CNT_W(8)) u_ram12 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a_o[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b_o[1]),
    .init_done(init_done_o[1]), .collision(collision_o[1]), .coll_cnt(coll_cnt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] mm   [NI][16];
  int         edges[NI];
  logic [7:0] s1a[NI], s1b[NI], oa[NI], ob[NI];
  logic       pena[NI], penb[NI];
  logic       ec[NI];
  int         ecnt[NI];

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int wfirst(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      edges[k] = 0;
      s1a[k] = 8'h00; s1b[k] = 8'h00; oa[k] = 8'h00; ob[k] = 8'h00;
      pena[k] = 1'b0; penb[k] = 1'b0;
      ec[k] = 1'b0; ecnt[k] = 0;
    end
  endtask

  // Predict each instance's state after the coming rising edge.
  task automatic model_edge();
    int  d, a, b;
    bit  rdy, wa, wb, coll;
    logic [7:0] na, nb;
    if (!rst_n) return;
    a = int'(addr_a);
    b = int'(addr_b);
    for (int k = 0; k < NI; k++) begin
      d   = dep(k);
      rdy = (edges[k] >= d);
      wa  = rdy && en_a && we_a && (a < d);
      wb  = rdy && en_b && we_b && (b < d);
      coll = wa && wb && (a == b);
      na = s1a[k];
      nb = s1b[k];
      if (rdy && en_a) na = (a >= d) ? 8'h00 : (we_a && wfirst(k) == 1) ? din_a : mm[k][a];
      if (rdy && en_b) nb = (b >= d) ? 8'h00 : (we_b && wfirst(k) == 1) ? din_b : mm[k][b];
`ifdef DPRAM_OUT_REG_EN
      if (pena[k]) oa[k] = s1a[k];
      if (penb[k]) ob[k] = s1b[k];
      pena[k] = rdy && en_a;
      penb[k] = rdy && en_b;
      s1a[k] = na;
      s1b[k] = nb;
`else
      s1a[k] = na;
      s1b[k] = nb;
      oa[k]  = na;
      ob[k]  = nb;
`endif
      if (wb && !coll) mm[k][b] = din_b;
      if (wa) mm[k][a] = din_a;
      ec[k] = coll;
      if (coll && ecnt[k] < 255) ecnt[k]++;
      if (!rdy) begin
        edges[k]++;
        if (edges[k] == d) for (int i = 0; i < 16; i++) mm[k][i] = 8'h00;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("dout_a[%0d]", k), 32'(dout_a_o[k]), 32'(oa[k]));
      chk($sformatf("dout_b[%0d]", k), 32'(dout_b_o[k]), 32'(ob[k]));
      chk($sformatf("init_done[%0d]", k), 32'(init_done_o[k]), 32'(edges[k] >= dep(k)));
      chk($sformatf("collision[%0d]", k), 32'(collision_o[k]), 32'(ec[k]));
      chk($sformatf("coll_cnt[%0d]", k), 32'(coll_cnt_o[k]), 32'(ecnt[k]));
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic ea, input logic wa, input int aa, input logic [7:0] da,
                       input logic eb, input logic wb, input int ab, input logic [7:0] db);
    en_a = ea; we_a = wa; addr_a = 4'(aa); din_a = da;
    en_b = eb; we_b = wb; addr_b = 4'(ab); din_b = db;
  endtask

  task automatic drive_random(input int amax);
    int a;
    a = $urandom_range(0, amax);
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, amax), 8'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 1, 3, 8'hEE, 1, 1, 3, 8'hDD);
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Clear phase: random requests must be ignored.
    for (int i = 0; i < 16; i++) begin
      drive_random(15);
      cycle();
    end

    // Whole array reads back zero.
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, i, 8'h00, 1, 0, 15 - i, 8'h00);
      cycle();
    end

    // Independent writes, then cross reads.
    drive(1, 1, 1, 8'hAA, 1, 1, 2, 8'h55); cycle();
    drive(1, 0, 2, 8'h00, 1, 0, 1, 8'h00); cycle();

    // Same-port and cross-port read-during-write at address 3.
    drive(1, 1, 3, 8'h11, 0, 0, 0, 8'h00); cycle();
    drive(1, 1, 3, 8'hF0, 1, 0, 3, 8'h00); cycle();
    drive(0, 0, 0, 8'h00, 1, 0, 3, 8'h00); cycle();

    // Write collision at address 5, then read back.
    drive(1, 1, 5, 8'h12, 1, 1, 5, 8'h34); cycle();
    drive(1, 0, 5, 8'h00, 1, 0, 5, 8'h00); cycle();
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00); cycle();

    // Saturate the collision counter.
    for (int i = 0; i < 300; i++) begin
      int a;
      a = $urandom_range(0, 11);
      drive(1, 1, a, 8'($urandom), 1, 1, a, 8'($urandom));
      cycle();
    end
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00); cycle();

    // Address 13 is out of range for the 12-word instance only.
    drive(1, 1, 13, 8'h77, 0, 0, 0, 8'h00); cycle();
    drive(1, 0, 13, 8'h00, 1, 0, 13, 8'h00); cycle();
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, i, 8'h00, 1, 1, 13, 8'($urandom));
      cycle();
    end

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_random(15);
      cycle();
    end

    // Reset mid-read, then confirm the clear reran.
    drive(1, 1, 4, 8'h99, 0, 0, 0, 8'h00); cycle();
    drive(1, 0, 4, 8'h00, 1, 0, 4, 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_random(15);
      cycle();
    end
    drive(1, 0, 4, 8'h00, 1, 0, 4, 8'h00); cycle();
    drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised true dual-port synchronous RAM. It is the next generation of the fixed 16x8 dual-port RAM.
- Adds configurable width and depth.
- Adds a selectable read-during-write mode and port-A-priority write-collision arbitration.
- Auto-clears the array after reset, with a done flag.
- Adds a saturating collision counter.
- Intended as the shared scratch/buffer memory between two independent masters in the same clock domain.

Parameters:
DATA_W, 8, word width in bits (>=1)
DEPTH, 16, number of words (>=2, need not be power of 2)
RDW_MODE, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)
CNT_W, 8, width of collision counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en_a  in  1  port A access enable
we_a  in  1  port A write enable (qualified by en_a)
addr_a  in  ADDR_W  port A address, ADDR_W = $clog2(DEPTH)
din_a  in  DATA_W  port A write data
dout_a  out  DATA_W  port A read data
en_b  in  1  port B access enable
we_b  in  1  port B write enable (qualified by en_b)
addr_b  in  ADDR_W  port B address
din_b  in  DATA_W  port B write data
dout_b  out  DATA_W  port B read data
init_done  out  1  high once post-reset clear is complete
collision  out  1  one-cycle pulse: both ports wrote the same address
coll_cnt  out  CNT_W  saturating count of collisions since reset

Behaviour:
- Reset (rst_n low, asynchronous): dout_a=0, dout_b=0, init_done=0, collision=0, coll_cnt=0, FSM->CLEAR, clear pointer=0. Array contents are not reset directly.
- FSM states:
  - CLEAR: writes 0 to address ptr each cycle and increments ptr.
  - At ptr==DEPTH-1, the write completes, FSM->READY and init_done=1 on the same edge.
  - init_done therefore rises on the DEPTH-th rising edge after rst_n deasserts.
  - READY is terminal until the next reset.
- During CLEAR: all port requests are ignored (no writes), dout_a/dout_b held at 0, collision never asserts.
- READY, per port x:
  - en_x=0: no access, dout_x holds its value.
  - en_x=1, we_x=0: dout_x <= mem[addr_x], latency 1 cycle.
  - en_x=1, we_x=1: mem[addr_x] <= din_x. dout_x gets the old word if RDW_MODE=0, or din_x if RDW_MODE=1.
- Cross-port read-during-write (A writes X, B reads X in the same cycle, or vice versa): the reader always gets the old data, regardless of RDW_MODE.
- Write collision (both ports writing the same in-range address in the same cycle):
  - Port A data is stored.
  - collision=1 for exactly the next cycle.
  - coll_cnt increments, saturating at 2^CNT_W-1.
  - Each port's own dout follows the RDW_MODE rules using that port's din.
- Out-of-range address (addr >= DEPTH, possible when DEPTH is not a power of 2):
  - Write is dropped.
  - Read returns 0.
  - Counts as no collision.
- Reset asserted mid-operation: takes effect immediately and the clear sequence reruns fully. Any in-flight write on that edge is lost.

Optional Feature:
Macro DPRAM_OUT_REG_EN.
- Defined: an extra output pipeline register on each dout, so read latency is 2 cycles. Register reset value is 0; enable rules are the same as the first stage. collision/coll_cnt timing is unchanged.
- Undefined: read latency is 1 cycle as above.

Decomposition:
- Package dpram_pkg holds:
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1 constants.
  - Enum typedef for the FSM states {CLEAR, READY}.
- One sub-module, dpram_clear_ctrl, holds:
  - The CLEAR/READY FSM and clear pointer.
  - Its outputs: clr_we, clr_addr and init_done.
- Top level holds the array, the port muxing, RDW logic and collision logic.

Test Plan:
- Release rst_n, DEPTH=16 -> init_done low for 15 edges, high on the 16th. Reading all addresses afterwards returns 0x00.
- Port A writes 0xAA@1 while port B writes 0x55@2 in the same cycle. Next cycle read A@2 and B@1 -> dout_a=0x55, dout_b=0xAA, collision=0.
- RDW_MODE=0: mem[3]=0x11, A writes 0xF0@3 -> dout_a=0x11. RDW_MODE=1, same stimulus -> dout_a=0xF0. Both modes: B reading @3 in the same cycle -> 0x11.
- A writes 0x12@5 and B writes 0x34@5 together -> mem[5]=0x12, one-cycle collision pulse, coll_cnt=1. Repeat 300 times with CNT_W=8 -> coll_cnt=255.
- DEPTH=12: write 0x77@13, then read @13 -> dout=0x00. mem[0..11] unchanged, no collision.
- Write 0x99@4, then assert rst_n low mid-read -> dout_a=0 immediately. After release and init_done, read @4 returns 0x00.
